// File: rtl/record_capture_ctrl_if.sv
// ---------------------------------------------------------------------------
// record_capture_ctrl_if
// Merged word stream leaving the capture controller (valid/ready).
//   outData  : captured 32-bit word
//   outChan  : channel that produced outData
//   outValid : word valid, held until accepted
//   outReady : downstream accept
// master = controller side, slave = DMA/FIFO side.
// ---------------------------------------------------------------------------
interface record_capture_ctrl_if #(
    parameter int unsigned CH_W = 2
);
    logic [31:0]     outData;
    logic [CH_W-1:0] outChan;
    logic            outValid;
    logic            outReady;

    modport master (
        output outData,
        output outChan,
        output outValid,
        input  outReady
    );

    modport slave (
        input  outData,
        input  outChan,
        input  outValid,
        output outReady
    );
endinterface

// File: rtl/record_capture_ctrl.sv
// ---------------------------------------------------------------------------
// record_capture_ctrl
// Sequences a bank of N_CH record units for one capture run, detects each
// completed word as a rising edge of chValid, buffers one word per channel
// and merges pending words round-robin onto a single tagged word stream.
//
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   start       : one-cycle pulse, begins a run (IDLE only)
//   stop        : one-cycle pulse, ends a run early (RUN only)
//   wordCount   : words per channel per run, 0 = unlimited (sampled on start)
//   chValid     : per-channel data-valid level
//   chData      : per-channel word, channel i at [32i+31:32i]
//   chEnable    : per-channel record enable
//   stream      : merged output stream (outData/outChan/outValid/outReady)
//   busy        : controller not idle
//   overflow    : sticky per-channel lost-word flags
//   done        : one-cycle pulse after the run has fully drained
// ---------------------------------------------------------------------------
module record_capture_ctrl #(
    parameter  int unsigned N_CH  = 4,
    parameter  int unsigned CNT_W = 16,
    localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic [CNT_W-1:0]         wordCount,
    input  logic [N_CH-1:0]          chValid,
    input  logic [N_CH*32-1:0]       chData,
    output logic [N_CH-1:0]          chEnable,
    record_capture_ctrl_if.master    stream,
    output logic                     busy,
    output logic [N_CH-1:0]          overflow,
    output logic                     done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            go_run;
    logic            go_drain;
    logic            go_idle;

    logic [N_CH-1:0]  prev;
    logic [N_CH-1:0]  pending;
    logic [N_CH-1:0]  cap;
    logic [N_CH-1:0]  hit;
    logic [N_CH-1:0]  pop;
    logic [31:0]      hold    [N_CH];
    logic [CNT_W-1:0] cnt     [N_CH];
    logic [CNT_W-1:0] cnt_inc [N_CH];
    logic [CNT_W-1:0] wc;

    logic            load;
    logic            grant_any;
    logic [CH_W-1:0] grant_idx;
    logic [CH_W-1:0] last;

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        go_run    = 1'b0;
        go_drain  = 1'b0;
        go_idle   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    go_run    = 1'b1;
                end
            end
            RUN: begin
                if (stop || (chEnable == '0)) begin
                    state_nxt = DRAIN;
                    go_drain  = 1'b1;
                end
            end
            DRAIN: begin
                if ((pending == '0) && !stream.outValid) begin
                    state_nxt = IDLE;
                    go_idle   = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // -----------------------------------------------------------------------
    // Word detection and counter terminal condition
    // -----------------------------------------------------------------------
    always_comb begin
        cap = '0;
        hit = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            cnt_inc[i] = (cnt[i] == '1) ? cnt[i] : cnt[i] + 1'b1;
            cap[i]     = (state == RUN) && chValid[i] && !prev[i] && chEnable[i];
            hit[i]     = cap[i] && (wc != '0) && (cnt_inc[i] == wc);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= '0;
        end else begin
            prev <= chValid;
        end
    end

    // -----------------------------------------------------------------------
    // Round-robin arbiter: scan starts one past the last granted channel and
    // only looks at words already held (captures this cycle wait a cycle).
    // -----------------------------------------------------------------------
    always_comb begin : arb_comb
        int unsigned idx;
        idx       = 0;
        load      = !stream.outValid || stream.outReady;
        grant_any = 1'b0;
        grant_idx = '0;
        pop       = '0;
        for (int unsigned j = 1; j <= N_CH; j++) begin
            idx = int'(last) + j;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (load && !grant_any && pending[idx]) begin
                grant_any = 1'b1;
                grant_idx = CH_W'(idx);
            end
        end
        if (grant_any) begin
            pop[grant_idx] = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Run control: word limit, enables, counters, overflow, done
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wc       <= '0;
            chEnable <= '0;
            overflow <= '0;
            done     <= 1'b0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            done <= go_idle;
            if (go_run) begin
                wc       <= wordCount;
                chEnable <= '1;
                overflow <= '0;
                for (int unsigned i = 0; i < N_CH; i++) begin
                    cnt[i] <= '0;
                end
            end else begin
                // A capture on the stop edge still counts; the enables all
                // drop regardless once the run leaves RUN.
                if (go_drain) begin
                    chEnable <= '0;
                end else begin
                    chEnable <= chEnable & ~hit;
                end
                for (int unsigned i = 0; i < N_CH; i++) begin
                    if (cap[i]) begin
                        cnt[i] <= cnt_inc[i];
                        if (pending[i] && !pop[i]) begin
                            overflow[i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Per-channel hold buffer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                hold[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (cap[i] && (!pending[i] || pop[i])) begin
                    hold[i]    <= chData[i*32 +: 32];
                    pending[i] <= 1'b1;
                end else if (pop[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stream.outData  <= '0;
            stream.outChan  <= '0;
            stream.outValid <= 1'b0;
            last            <= CH_W'(N_CH - 1);
        end else if (load) begin
            if (grant_any) begin
                stream.outData  <= hold[grant_idx];
                stream.outChan  <= grant_idx;
                stream.outValid <= 1'b1;
                last            <= grant_idx;
            end else begin
                stream.outValid <= 1'b0;
            end
        end
    end

endmodule
